// File: rtl/int_entry_ctrl_if.sv
// Bus between the core pipeline and the interrupt entry/return sequencer.
// The core (master) supplies pending levels and state; the sequencer (slave) returns strobes.
interface int_entry_ctrl_if;
    logic        int_irq;
    logic        int_fiq;
    logic        step;
    logic        eret;
    logic [31:0] pc_cur;
    logic [31:0] cpsr_in;
    logic        inta_irq;
    logic        inta_fiq;
    logic        pc_load;
    logic [31:0] pc_next;
    logic        lr_we;
    logic [31:0] lr_out;
    logic        spsr_we;
    logic [31:0] spsr_out;
    logic        cpsr_we;
    logic [31:0] cpsr_out;
    logic        busy;
    logic [1:0]  depth;

    modport master (
        output int_irq, int_fiq, step, eret, pc_cur, cpsr_in,
        input  inta_irq, inta_fiq, pc_load, pc_next, lr_we, lr_out,
               spsr_we, spsr_out, cpsr_we, cpsr_out, busy, depth
    );

    modport slave (
        input  int_irq, int_fiq, step, eret, pc_cur, cpsr_in,
        output inta_irq, inta_fiq, pc_load, pc_next, lr_we, lr_out,
               spsr_we, spsr_out, cpsr_we, cpsr_out, busy, depth
    );
endinterface

// File: rtl/int_entry_ctrl.sv
// IRQ/FIQ exception entry and return sequencer with one level of FIQ-over-IRQ nesting.
// Strobes and data are registered from the next state so they line up with the state cycle.
module int_entry_ctrl (
    input  logic             clk,
    input  logic             clr,
    int_entry_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ACK, SAVE, JUMP, SERVICE, RESTORE} state_t;

    state_t      state, state_next;
    logic        kind, kind_next;          // 0 = IRQ, 1 = FIQ
    logic [1:0]  depth, depth_next;
    logic [31:0] ret_irq, sv_irq, ret_fiq, sv_fiq;
    logic        latch, fiq_ok, irq_ok;
    logic [31:0] act_ret, act_sv;

    logic        inta_irq_d, inta_fiq_d, pc_load_d, lr_we_d, spsr_we_d, cpsr_we_d;
    logic [31:0] pc_next_d, lr_out_d, spsr_out_d, cpsr_out_d;
    logic        inta_irq_q, inta_fiq_q, pc_load_q, lr_we_q, spsr_we_q, cpsr_we_q;
    logic [31:0] pc_next_q, lr_out_q, spsr_out_q, cpsr_out_q;

    assign fiq_ok  = bus.int_fiq && !bus.cpsr_in[6];
    assign irq_ok  = bus.int_irq && !bus.cpsr_in[7];
    assign act_ret = kind ? ret_fiq : ret_irq;
    assign act_sv  = kind ? sv_fiq  : sv_irq;

    always_comb begin
        state_next = state;
        kind_next  = kind;
        depth_next = depth;
        latch      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.step && (fiq_ok || irq_ok)) begin
                    latch      = 1'b1;
                    kind_next  = fiq_ok;
                    state_next = ACK;
                end
            end
            ACK:  state_next = SAVE;
            SAVE: begin
                state_next = JUMP;
                depth_next = depth + 2'd1;
            end
            JUMP: state_next = SERVICE;
            SERVICE: begin
                // Return wins over a simultaneous preempting FIQ.
                if (bus.eret) begin
                    state_next = RESTORE;
                    depth_next = depth - 2'd1;
                end else if (!kind && depth == 2'd1 && bus.step && fiq_ok) begin
                    latch      = 1'b1;
                    kind_next  = 1'b1;
                    state_next = ACK;
                end
            end
            RESTORE: begin
                if (depth == 2'd0) begin
                    state_next = IDLE;
                end else begin
                    state_next = SERVICE;
                    kind_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        inta_irq_d = 1'b0;
        inta_fiq_d = 1'b0;
        pc_load_d  = 1'b0;
        lr_we_d    = 1'b0;
        spsr_we_d  = 1'b0;
        cpsr_we_d  = 1'b0;
        pc_next_d  = 32'h0;
        lr_out_d   = 32'h0;
        spsr_out_d = 32'h0;
        cpsr_out_d = 32'h0;
        case (state_next)
            ACK: begin
                inta_irq_d = !kind_next;
                inta_fiq_d = kind_next;
            end
            SAVE: begin
                lr_we_d    = 1'b1;
                lr_out_d   = act_ret + 32'd4;
                spsr_we_d  = 1'b1;
                spsr_out_d = act_sv;
            end
            JUMP: begin
                pc_load_d = 1'b1;
                cpsr_we_d = 1'b1;
                if (kind) begin
                    pc_next_d  = 32'h0000_001C;
                    cpsr_out_d = {act_sv[31:8], 2'b11, act_sv[5], 5'b10001};
                end else begin
                    pc_next_d  = 32'h0000_0018;
                    cpsr_out_d = {act_sv[31:8], 1'b1, act_sv[6:5], 5'b10010};
                end
            end
            RESTORE: begin
                pc_load_d  = 1'b1;
                pc_next_d  = act_ret;
                cpsr_we_d  = 1'b1;
                cpsr_out_d = act_sv;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            kind    <= 1'b0;
            depth   <= 2'd0;
            ret_irq <= 32'h0;
            sv_irq  <= 32'h0;
            ret_fiq <= 32'h0;
            sv_fiq  <= 32'h0;
        end else begin
            state <= state_next;
            kind  <= kind_next;
            depth <= depth_next;
            if (latch && kind_next) begin
                ret_fiq <= bus.pc_cur;
                sv_fiq  <= bus.cpsr_in;
            end else if (latch) begin
                ret_irq <= bus.pc_cur;
                sv_irq  <= bus.cpsr_in;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            inta_irq_q <= 1'b0;
            inta_fiq_q <= 1'b0;
            pc_load_q  <= 1'b0;
            lr_we_q    <= 1'b0;
            spsr_we_q  <= 1'b0;
            cpsr_we_q  <= 1'b0;
            pc_next_q  <= 32'h0;
            lr_out_q   <= 32'h0;
            spsr_out_q <= 32'h0;
            cpsr_out_q <= 32'h0;
        end else begin
            inta_irq_q <= inta_irq_d;
            inta_fiq_q <= inta_fiq_d;
            pc_load_q  <= pc_load_d;
            lr_we_q    <= lr_we_d;
            spsr_we_q  <= spsr_we_d;
            cpsr_we_q  <= cpsr_we_d;
            pc_next_q  <= pc_next_d;
            lr_out_q   <= lr_out_d;
            spsr_out_q <= spsr_out_d;
            cpsr_out_q <= cpsr_out_d;
        end
    end

    assign bus.inta_irq = inta_irq_q;
    assign bus.inta_fiq = inta_fiq_q;
    assign bus.pc_load  = pc_load_q;
    assign bus.pc_next  = pc_next_q;
    assign bus.lr_we    = lr_we_q;
    assign bus.lr_out   = lr_out_q;
    assign bus.spsr_we  = spsr_we_q;
    assign bus.spsr_out = spsr_out_q;
    assign bus.cpsr_we  = cpsr_we_q;
    assign bus.cpsr_out = cpsr_out_q;
    assign bus.busy     = (state != IDLE);
    assign bus.depth    = depth;
endmodule

// File: tb/tb_int_entry_ctrl.sv
// Directed bench for int_entry_ctrl: entry, priority, masking, nesting, return and reset.
module tb_int_entry_ctrl;
    logic clk;
    logic clr;
    int   checks;
    int   errors;

    int_entry_ctrl_if bus ();

    int_entry_ctrl dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive inputs, then advance one rising edge and settle just after it.
    task automatic applyStimulus(input logic irq, input logic fiq, input logic stp, input logic ert,
                                 input logic [31:0] pc, input logic [31:0] cpsr);
        bus.int_irq = irq;
        bus.int_fiq = fiq;
        bus.step    = stp;
        bus.eret    = ert;
        bus.pc_cur  = pc;
        bus.cpsr_in = cpsr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_inta_irq"}, {31'h0, bus.inta_irq}, 32'h0);
        checkOutput({tag, "_inta_fiq"}, {31'h0, bus.inta_fiq}, 32'h0);
        checkOutput({tag, "_pc_load"},  {31'h0, bus.pc_load},  32'h0);
        checkOutput({tag, "_pc_next"},  bus.pc_next,           32'h0);
        checkOutput({tag, "_lr_we"},    {31'h0, bus.lr_we},    32'h0);
        checkOutput({tag, "_lr_out"},   bus.lr_out,            32'h0);
        checkOutput({tag, "_spsr_out"}, bus.spsr_out,          32'h0);
        checkOutput({tag, "_cpsr_out"}, bus.cpsr_out,          32'h0);
        checkOutput({tag, "_busy"},     {31'h0, bus.busy},     32'h0);
        checkOutput({tag, "_depth"},    {30'h0, bus.depth},    32'h0);
    endtask

    // Full four-cycle entry starting from a cycle where the take condition holds.
    task automatic runEntry(input string tag, input logic irq, input logic fiq,
                            input logic [31:0] pc, input logic [31:0] cpsr,
                            input logic [31:0] exp_lr, input logic [31:0] exp_spsr,
                            input logic [31:0] exp_pc, input logic [31:0] exp_cpsr,
                            input logic [1:0] exp_depth);
        applyStimulus(irq, fiq, 1'b1, 1'b0, pc, cpsr);
        checkOutput({tag, "_ack_irq"},  {31'h0, bus.inta_irq}, {31'h0, !fiq});
        checkOutput({tag, "_ack_fiq"},  {31'h0, bus.inta_fiq}, {31'h0, fiq});
        checkOutput({tag, "_ack_busy"}, {31'h0, bus.busy},     32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, pc, cpsr);
        checkOutput({tag, "_save_ack"},  {31'h0, bus.inta_irq | bus.inta_fiq}, 32'h0);
        checkOutput({tag, "_save_lrwe"}, {31'h0, bus.lr_we},   32'h1);
        checkOutput({tag, "_save_lr"},   bus.lr_out,           exp_lr);
        checkOutput({tag, "_save_spwe"}, {31'h0, bus.spsr_we}, 32'h1);
        checkOutput({tag, "_save_spsr"}, bus.spsr_out,         exp_spsr);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, pc, cpsr);
        checkOutput({tag, "_jump_load"},  {31'h0, bus.pc_load}, 32'h1);
        checkOutput({tag, "_jump_pc"},    bus.pc_next,          exp_pc);
        checkOutput({tag, "_jump_cpwe"},  {31'h0, bus.cpsr_we}, 32'h1);
        checkOutput({tag, "_jump_cpsr"},  bus.cpsr_out,         exp_cpsr);
        checkOutput({tag, "_jump_lrwe"},  {31'h0, bus.lr_we},   32'h0);
        checkOutput({tag, "_jump_depth"}, {30'h0, bus.depth},   {30'h0, exp_depth});
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, pc, cpsr);
        checkOutput({tag, "_svc_load"}, {31'h0, bus.pc_load}, 32'h0);
        checkOutput({tag, "_svc_pc"},   bus.pc_next,          32'h0);
        checkOutput({tag, "_svc_cpsr"}, bus.cpsr_out,         32'h0);
        checkOutput({tag, "_svc_busy"}, {31'h0, bus.busy},    32'h1);
    endtask

    // eret from SERVICE; expects the RESTORE cycle values and the landing state.
    task automatic runReturn(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_cpsr,
                             input logic [1:0] exp_depth, input logic exp_busy_after);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        checkOutput({tag, "_load"},  {31'h0, bus.pc_load}, 32'h1);
        checkOutput({tag, "_pc"},    bus.pc_next,          exp_pc);
        checkOutput({tag, "_cpwe"},  {31'h0, bus.cpsr_we}, 32'h1);
        checkOutput({tag, "_cpsr"},  bus.cpsr_out,         exp_cpsr);
        checkOutput({tag, "_depth"}, {30'h0, bus.depth},   {30'h0, exp_depth});
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput({tag, "_after_load"}, {31'h0, bus.pc_load}, 32'h0);
        checkOutput({tag, "_after_busy"}, {31'h0, bus.busy},    {31'h0, exp_busy_after});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr    = 1'b1;
        bus.int_irq = 1'b0;
        bus.int_fiq = 1'b0;
        bus.step    = 1'b0;
        bus.eret    = 1'b0;
        bus.pc_cur  = 32'h0;
        bus.cpsr_in = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        clr = 1'b0;

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h13);
        checkAllZero("eret_idle");

        runEntry("irq", 1'b1, 1'b0, 32'h100, 32'h13, 32'h104, 32'h13, 32'h18, 32'h92, 2'd1);
        runReturn("irq_ret", 32'h100, 32'h13, 2'd0, 1'b0);

        runEntry("prio", 1'b1, 1'b1, 32'h100, 32'h13, 32'h104, 32'h13, 32'h1C, 32'hD1, 2'd1);
        runReturn("prio_ret", 32'h100, 32'h13, 2'd0, 1'b0);

        // Masked IRQ must not be taken; then unmasked without step, then with step.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h93);
        checkOutput("mask_busy", {31'h0, bus.busy}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h93);
        checkOutput("mask_ack", {31'h0, bus.inta_irq}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h13);
        checkOutput("nostep_busy", {31'h0, bus.busy}, 32'h0);
        runEntry("unmask", 1'b1, 1'b0, 32'h100, 32'h13, 32'h104, 32'h13, 32'h18, 32'h92, 2'd1);

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h180, 32'h12);
        checkOutput("irq_nopreempt_ack", {31'h0, bus.inta_irq}, 32'h0);
        checkOutput("irq_nopreempt_depth", {30'h0, bus.depth}, 32'h1);
        runEntry("nest", 1'b0, 1'b1, 32'h200, 32'h12, 32'h204, 32'h12, 32'h1C, 32'hD1, 2'd2);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h280, 32'h12);
        checkOutput("fiq_nopreempt_ack", {31'h0, bus.inta_fiq}, 32'h0);
        checkOutput("fiq_nopreempt_depth", {30'h0, bus.depth}, 32'h2);
        runReturn("nest_ret1", 32'h200, 32'h12, 2'd1, 1'b1);
        checkOutput("nest_ret1_depth", {30'h0, bus.depth}, 32'h1);
        runReturn("nest_ret2", 32'h100, 32'h13, 2'd0, 1'b0);

        // eret together with a qualifying FIQ: return must win.
        runEntry("race", 1'b1, 1'b0, 32'h300, 32'h13, 32'h304, 32'h13, 32'h18, 32'h92, 2'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h340, 32'h12);
        checkOutput("race_ack",   {31'h0, bus.inta_fiq}, 32'h0);
        checkOutput("race_load",  {31'h0, bus.pc_load},  32'h1);
        checkOutput("race_pc",    bus.pc_next,           32'h300);
        checkOutput("race_depth", {30'h0, bus.depth},    32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("race_busy", {31'h0, bus.busy}, 32'h0);

        // Reset in the middle of SAVE.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h400, 32'h13);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h400, 32'h13);
        checkOutput("clr_pre_lrwe", {31'h0, bus.lr_we}, 32'h1);
        #2;
        clr = 1'b1;
        #1;
        checkAllZero("clr_save");
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h400, 32'h13);
            checkOutput("clr_no_load", {31'h0, bus.pc_load}, 32'h0);
            checkOutput("clr_idle",    {31'h0, bus.busy},    32'h0);
        end

        // After reset the bank must be refilled from a fresh take.
        runEntry("post_clr", 1'b1, 1'b0, 32'h500, 32'h10, 32'h504, 32'h10, 32'h18, 32'h92, 2'd1);
        runReturn("post_clr_ret", 32'h500, 32'h10, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
